// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM state encoding,
// decoder branch codes and the load/store opcodes the sequencer inspects.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] NO_JUMP = 2'd0;
    localparam logic [1:0] BEQ     = 2'd1;
    localparam logic [1:0] BLT     = 2'd2;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LD) || (opcode == OP_SD);
    endfunction

endpackage

// File: rtl/core_sequencer_branch.sv
// core_branch_unit: combinational branch resolution (taken flag, wrapped
// target pc and the zero-offset self-loop halt flag).
module core_branch_unit
    import core_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [1:0]          branch,
    input  logic                dir,
    input  logic [4:0]          off,
    input  logic                zero,
    input  logic                neg,
    output logic                is_branch,
    output logic                taken,
    output logic                halt_loop,
    output logic [PC_WIDTH-1:0] target
);

    logic [PC_WIDTH-1:0] off_ext;

    assign off_ext   = PC_WIDTH'(off);
    assign is_branch = (branch == BEQ) || (branch == BLT);
    assign taken     = ((branch == BEQ) && zero) || ((branch == BLT) && neg);
    // A taken branch by zero instructions would spin forever; report it instead.
    assign halt_loop = taken && (off == 5'd0);
    // Arithmetic is at PC_WIDTH bits so the target wraps modulo 2^PC_WIDTH.
    assign target    = dir ? (pc - off_ext) : (pc + off_ext);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM sequencing fetch/decode/exec/mem/writeback.
// Optional CORE_SEQ_PERF_EN adds saturating cycle_cnt and retired_cnt outputs.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic [INST_WIDTH-1:0] inst,
    input  logic                  dec_reg_we,
    input  logic                  dec_data_we,
    input  logic [1:0]            dec_branch,
    input  logic                  dec_branch_dir,
    input  logic [4:0]            dec_branch_off,
    input  logic                  alu_zero,
    input  logic                  alu_neg,
    output logic                  dmem_req,
    input  logic                  dmem_ack,
    output logic                  reg_we,
    output logic                  data_we,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  busy,
    output logic [2:0]            dbg_state,
    output logic                  halted
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           retired_cnt
`endif
);

    // Handshake: a request (imem_req/dmem_req) is a pure decode of the
    // registered state, held until its ack; an ack without a request is ignored.
    state_t                state, next_state;
    logic [PC_WIDTH-1:0]   pc_q, next_pc, pc_inc, br_target;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  br_is_branch, br_taken, br_halt;

    assign pc_inc = pc_q + PC_WIDTH'(1);

    core_branch_unit #(.PC_WIDTH(PC_WIDTH)) u_branch (
        .pc        (pc_q),
        .branch    (dec_branch),
        .dir       (dec_branch_dir),
        .off       (dec_branch_off),
        .zero      (alu_zero),
        .neg       (alu_neg),
        .is_branch (br_is_branch),
        .taken     (br_taken),
        .halt_loop (br_halt),
        .target    (br_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc_q   <= '0;
            inst_q <= '0;
        end else begin
            state <= next_state;
            pc_q  <= next_pc;
            if (state == ST_FETCH && imem_ack) inst_q <= imem_rdata;
        end
    end

    always_comb begin
        next_state = state;
        next_pc    = pc_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        reg_we     = 1'b0;
        data_we    = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    next_state = ST_FETCH;
                    next_pc    = '0;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) next_state = (imem_rdata == '0) ? ST_HALT : ST_DECODE;
            end
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC: begin
                if (br_is_branch) begin
                    if (br_taken && br_halt) begin
                        next_state = ST_HALT;
                    end else begin
                        next_state = ST_FETCH;
                        next_pc    = br_taken ? br_target : pc_inc;
                    end
                end else if ((dec_reg_we || dec_data_we) && is_mem_op(inst_q[6:0])) begin
                    next_state = ST_MEM;
                end else if (dec_reg_we) begin
                    next_state = ST_WB;
                end else begin
                    next_state = ST_FETCH;
                    next_pc    = pc_inc;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (inst_q[6:0] == OP_SD) begin
                        data_we    = 1'b1;
                        next_state = ST_FETCH;
                        next_pc    = pc_inc;
                    end else begin
                        next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                next_state = ST_FETCH;
                next_pc    = pc_inc;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;
    assign busy      = (state != ST_IDLE) && (state != ST_HALT);
    assign halted    = (state == ST_HALT);
    assign dbg_state = state;

`ifdef CORE_SEQ_PERF_EN
    logic restart, retire;

    assign restart = ((state == ST_IDLE) || (state == ST_HALT)) && start;
    assign retire  = (next_state == ST_FETCH) &&
                     ((state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else if (restart) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (busy && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire && (retired_cnt != '1)) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule
